// File: rtl/ccb_pkg.sv
// Shared types and widths for the CCB lock-line filter.
package ccb_pkg;
  localparam int unsigned GLITCH_W = 8;
  localparam int unsigned DWELL_W  = 8;

  typedef enum logic [1:0] {
    F_LOW  = 2'd0,
    F_RISE = 2'd1,
    F_HIGH = 2'd2,
    F_FALL = 2'd3
  } filt_state_t;
endpackage

// File: rtl/ccb_lock_filter_if.sv
// Signal bundle between the CCB lock-line filter and its environment.
interface ccb_lock_filter_if;
  import ccb_pkg::*;

  logic                lock_raw;
  logic                glitch_clr;
  logic                lock_sync;
  logic                lock_out;
  logic [GLITCH_W-1:0] glitch_cnt;
  logic [1:0]          filt_state;

  modport master (
    output lock_raw, glitch_clr,
    input  lock_sync, lock_out, glitch_cnt, filt_state
  );

  modport slave (
    input  lock_raw, glitch_clr,
    output lock_sync, lock_out, glitch_cnt, filt_state
  );
endinterface

// File: rtl/ccb_lock_filter_sync_ff.sv
// Plain multi-stage synchronizer for a single asynchronous bit, async active-low clear.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= {r_q[STAGES-2:0], i_d};
  end

  assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/ccb_lock_filter.sv
// Synchronizes the raw CCB TTC lock line, qualifies each edge with a dwell time and
// counts unqualified edges (glitches) in a saturating counter.
module ccb_lock_filter
  import ccb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ON_DLY      = 16,
  parameter int unsigned OFF_DLY     = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  ccb_lock_filter_if.slave  bus
);
  logic                w_lock_sync;
  filt_state_t         r_state, w_state_nxt;
  logic [DWELL_W-1:0]  r_dwell, w_dwell_nxt;
  logic                r_lock_out, w_lock_out_nxt;
  logic                w_glitch;
  logic [GLITCH_W-1:0] r_glitch_cnt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clock),
    .rst_n (reset_n),
    .i_d   (bus.lock_raw),
    .o_q   (w_lock_sync)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= F_LOW;
      r_dwell    <= '0;
      r_lock_out <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dwell    <= w_dwell_nxt;
      r_lock_out <= w_lock_out_nxt;
    end
  end

  // lock_out only moves on a fully qualified edge; an edge that reverts early is a glitch
  always_comb begin
    w_state_nxt    = r_state;
    w_dwell_nxt    = r_dwell;
    w_lock_out_nxt = r_lock_out;
    w_glitch       = 1'b0;
    case (r_state)
      F_LOW: begin
        if (w_lock_sync) begin
          w_state_nxt = F_RISE;
          w_dwell_nxt = '0;
        end
      end
      F_RISE: begin
        if (!w_lock_sync) begin
          w_state_nxt = F_LOW;
          w_glitch    = 1'b1;
        end else if (r_dwell == DWELL_W'(ON_DLY - 1)) begin
          w_state_nxt    = F_HIGH;
          w_lock_out_nxt = 1'b1;
        end else begin
          w_dwell_nxt = r_dwell + 1'b1;
        end
      end
      F_HIGH: begin
        if (!w_lock_sync) begin
          w_state_nxt = F_FALL;
          w_dwell_nxt = '0;
        end
      end
      F_FALL: begin
        if (w_lock_sync) begin
          w_state_nxt = F_HIGH;
          w_glitch    = 1'b1;
        end else if (r_dwell == DWELL_W'(OFF_DLY - 1)) begin
          w_state_nxt    = F_LOW;
          w_lock_out_nxt = 1'b0;
        end else begin
          w_dwell_nxt = r_dwell + 1'b1;
        end
      end
      default: begin
        w_state_nxt    = F_LOW;
        w_lock_out_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                         r_glitch_cnt <= '0;
    else if (bus.glitch_clr)              r_glitch_cnt <= '0;
    else if (w_glitch && r_glitch_cnt != '1) r_glitch_cnt <= r_glitch_cnt + 1'b1;
  end

  assign bus.lock_sync  = w_lock_sync;
  assign bus.lock_out   = r_lock_out;
  assign bus.glitch_cnt = r_glitch_cnt;
  assign bus.filt_state = r_state;
endmodule

// File: tb/tb_ccb_lock_filter.sv
// Bench for ccb_lock_filter: directed vector table, corner sequences and random
// stimulus checked against a run-length model of the lock filter.
`timescale 1ns/1ps
module tb_ccb_lock_filter;
  localparam int unsigned SYNC = 2;
  localparam int unsigned ON   = 16;
  localparam int unsigned OFF  = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #12 clock = ~clock;

  ccb_lock_filter_if ifc ();

  ccb_lock_filter #(.SYNC_STAGES(SYNC), .ON_DLY(ON), .OFF_DLY(OFF)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: filtered level, length of the current run of synced samples that
  // disagree with it, and the raw samples still travelling through the synchronizer.
  logic        m_sync [SYNC];
  logic        m_out;
  int unsigned m_run;
  int unsigned m_cnt;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    m_out = 1'b0;
    m_run = 0;
    m_cnt = 0;
  endtask

  task automatic chk_model();
    chk("lock_sync",  32'(ifc.lock_sync),  32'(m_sync[SYNC-1]));
    chk("lock_out",   32'(ifc.lock_out),   32'(m_out));
    chk("glitch_cnt", 32'(ifc.glitch_cnt), m_cnt);
    chk("filt_state", 32'(ifc.filt_state), {30'd0, m_out, (m_run != 0)});
  endtask

  task automatic step(input logic raw, input logic clr);
    logic ls;
    logic glitch;
    ifc.lock_raw   = raw;
    ifc.glitch_clr = clr;
    @(posedge clock);
    ls     = m_sync[SYNC-1];
    glitch = 1'b0;
    if (ls != m_out) begin
      m_run++;
      if (m_run == (m_out ? OFF : ON) + 1) begin
        m_out = ~m_out;
        m_run = 0;
      end
    end else begin
      glitch = (m_run != 0);
      m_run  = 0;
    end
    if (clr)                      m_cnt = 0;
    else if (glitch && m_cnt < 255) m_cnt++;
    for (int unsigned i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = raw;
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    chk("rst_lock_out",   32'(ifc.lock_out),   0);
    chk("rst_glitch_cnt", 32'(ifc.glitch_cnt), 0);
    chk("rst_filt_state", 32'(ifc.filt_state), 0);
    chk("rst_lock_sync",  32'(ifc.lock_sync),  0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        raw;
    logic        clr;
    int unsigned cycles;
    logic        exp_out;
    int unsigned exp_cnt;
    int unsigned exp_state;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int unsigned len;
    logic        lvl;

    vecs[0] = '{raw:1'b1, clr:1'b0, cycles:18, exp_out:1'b0, exp_cnt:0, exp_state:1};
    vecs[1] = '{raw:1'b1, clr:1'b0, cycles:1,  exp_out:1'b1, exp_cnt:0, exp_state:2};
    vecs[2] = '{raw:1'b0, clr:1'b0, cycles:3,  exp_out:1'b1, exp_cnt:0, exp_state:3};
    vecs[3] = '{raw:1'b1, clr:1'b0, cycles:3,  exp_out:1'b1, exp_cnt:1, exp_state:2};
    vecs[4] = '{raw:1'b0, clr:1'b0, cycles:6,  exp_out:1'b1, exp_cnt:1, exp_state:3};
    vecs[5] = '{raw:1'b0, clr:1'b0, cycles:1,  exp_out:1'b0, exp_cnt:1, exp_state:0};
    vecs[6] = '{raw:1'b0, clr:1'b1, cycles:1,  exp_out:1'b0, exp_cnt:0, exp_state:0};

    ifc.lock_raw   = 1'b0;
    ifc.glitch_clr = 1'b0;
    do_reset();

    // Qualified rise (lock_out at step 19), short drop, qualified fall, clear
    for (int unsigned v = 0; v < 7; v++) begin
      for (int unsigned c = 0; c < vecs[v].cycles; c++) step(vecs[v].raw, vecs[v].clr);
      chk($sformatf("vec%0d_lock_out", v),   32'(ifc.lock_out),   32'(vecs[v].exp_out));
      chk($sformatf("vec%0d_glitch_cnt", v), 32'(ifc.glitch_cnt), vecs[v].exp_cnt);
      chk($sformatf("vec%0d_filt_state", v), 32'(ifc.filt_state), vecs[v].exp_state);
    end

    // One-cycle synced pulse: one glitch, then the same with a simultaneous clear
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("pulse_rise_state", 32'(ifc.filt_state), 1);
    step(1'b0, 1'b0);
    chk("pulse_glitch_cnt", 32'(ifc.glitch_cnt), 1);
    chk("pulse_lock_out",   32'(ifc.lock_out),   0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    chk("clr_wins_cnt",   32'(ifc.glitch_cnt), 0);
    chk("clr_wins_state", 32'(ifc.filt_state), 0);

    // Saturation: 300 short pulses never qualify
    for (int unsigned p = 0; p < 300; p++) begin
      for (int unsigned c = 0; c < 5; c++) step(1'b1, 1'b0);
      for (int unsigned c = 0; c < 5; c++) step(1'b0, 1'b0);
    end
    chk("sat_glitch_cnt", 32'(ifc.glitch_cnt), 255);
    chk("sat_lock_out",   32'(ifc.lock_out),   0);
    step(1'b0, 1'b1);
    chk("sat_clr", 32'(ifc.glitch_cnt), 0);

    // Reset in the middle of a rise qualification
    for (int unsigned c = 0; c < 13; c++) step(1'b1, 1'b0);
    chk("midrise_state", 32'(ifc.filt_state), 1);
    do_reset();
    for (int unsigned c = 0; c < 18; c++) step(1'b1, 1'b0);
    chk("requal_still_low", 32'(ifc.lock_out), 0);
    step(1'b1, 1'b0);
    chk("requal_rise", 32'(ifc.lock_out), 1);

    // Random run lengths straddling both dwell thresholds, plus toggling
    lvl = 1'b0;
    for (int unsigned r = 0; r < 400; r++) begin
      lvl = ~lvl;
      len = (r % 50 < 5) ? 1 : $urandom_range(1, 22);
      for (int unsigned c = 0; c < len; c++) step(lvl, ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
